// File: rtl/fetch_stall_unit_pkg.sv
// fetch_stall_unit_pkg: shared opcodes, bubble encoding, stall limit and fetch state encoding
package fetch_stall_unit_pkg;
  localparam logic [15:0] NOP_INSTR = 16'hF000;
  localparam logic [15:0] PC_RESET = 16'h0000;
  localparam logic [1:0] MAX_STALL = 2'd3;
  localparam logic [3:0] OP_EXEC = 4'h7;
  localparam logic [3:0] OP_LW = 4'h8;
  localparam logic [3:0] OP_SW = 4'h9;
  localparam logic [3:0] OP_LHB = 4'hA;
  localparam logic [3:0] OP_LLB = 4'hB;
  localparam logic [3:0] OP_JR = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] HALT_OP = 4'hE;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALT = 2'd2} state_t;
endpackage

// File: rtl/fetch_stall_unit_if.sv
// fetch_stall_unit_if: fetch-stage bus; master = fetch unit, slave = imem/detector/downstream side
//   imem_addr/imem_rdata: instruction memory; hazard: detector flag for if_id_instr
//   redirect_valid/redirect_pc: resolved branch target; if_id_*, issue_*: IF/ID and ID/EX issue
//   stall_cnt/stall_overflow/halted: stall and halt status
interface fetch_stall_unit_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic hazard;
  logic redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc1;
  logic [15:0] issue_instr;
  logic issue_valid;
  logic [1:0] stall_cnt;
  logic stall_overflow;
  logic halted;
  modport master (
    output imem_addr, if_id_instr, if_id_pc1, issue_instr, issue_valid, stall_cnt, stall_overflow, halted,
    input imem_rdata, hazard, redirect_valid, redirect_pc
  );
  modport slave (
    input imem_addr, if_id_instr, if_id_pc1, issue_instr, issue_valid, stall_cnt, stall_overflow, halted,
    output imem_rdata, hazard, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stall_unit_pc_reg.sv
// pc_reg: program counter with load (redirect) over increment (fetch) over hold
//   clk/rst: clock, sync active-high reset; load/load_pc: redirect; inc: advance; pc: current PC
module pc_reg import fetch_stall_unit_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        inc,
  input  logic [15:0] load_pc,
  output logic [15:0] pc
);
  always_ff @(posedge clk)
    pc <= rst ? PC_RESET : load ? load_pc : inc ? pc + 16'd1 : pc;
endmodule

// File: rtl/fetch_stall_unit.sv
// fetch_stall_unit: instruction fetch + IF/ID register with hazard stalls, forced release, redirect flush and HLT
//   clk/rst: clock, sync active-high reset; bus: fetch_stall_unit_if master (imem, detector, redirect, issue, status)
module fetch_stall_unit import fetch_stall_unit_pkg::*; (
  input logic clk,
  input logic rst,
  fetch_stall_unit_if.master bus
);
  state_t state, state_n;
  logic [15:0] pc, ir, pc1;
  logic [1:0] cnt, cnt_n;
  logic ir_valid, ovf, forced, go, halt_issue, fetch;
  // go: IF/ID issues this cycle (normal advance or forced release after MAX_STALL bubbles)
  always_comb begin
    forced = state == STALL && bus.hazard && cnt == MAX_STALL;
    go = state != HALT && (!bus.hazard || forced);
    halt_issue = go && ir_valid && ir[15:12] == HALT_OP;
    fetch = !bus.redirect_valid && go && !halt_issue;
    state_n = bus.redirect_valid ? RUN : (state == HALT || halt_issue) ? HALT : go ? RUN : STALL;
    cnt_n = (bus.redirect_valid || go || state == HALT) ? 2'd0 : cnt + 2'd1;
  end
  pc_reg u_pc (.clk, .rst, .load(bus.redirect_valid), .inc(fetch), .load_pc(bus.redirect_pc), .pc);
  // ir_valid separates fetched words from bubbles so a flushed IF/ID never issues as valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= 2'd0;
      ovf <= 1'b0;
      ir <= NOP_INSTR;
      ir_valid <= 1'b0;
      pc1 <= 16'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ovf <= ovf | forced;
      if (fetch) begin
        ir <= bus.imem_rdata;
        ir_valid <= 1'b1;
        pc1 <= pc + 16'd1;
      end else if (bus.redirect_valid || halt_issue) begin
        ir <= NOP_INSTR;
        ir_valid <= 1'b0;
      end
    end
  end
  assign bus.imem_addr = pc;
  assign bus.if_id_instr = ir;
  assign bus.if_id_pc1 = pc1;
  assign bus.issue_instr = go ? ir : NOP_INSTR;
  assign bus.issue_valid = go && ir_valid;
  assign bus.stall_cnt = cnt;
  assign bus.stall_overflow = ovf;
  assign bus.halted = state == HALT;
endmodule

// File: tb/tb_fetch_stall_unit.sv
// tb_fetch_stall_unit: scoreboard bench for fetch_stall_unit against a rule-level fetch model
module tb_fetch_stall_unit;
  typedef struct {
    logic [15:0] addr, ir, pc1, iss;
    logic iv, ovf, hlt;
    logic [1:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] imem [256];
  exp_t sq [$];
  logic [15:0] iq [$];
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] m_pc, m_ir, m_pc1;
  logic m_fetched, m_halt, m_ovf;
  int m_stalls;
  fetch_stall_unit_if bus ();
  fetch_stall_unit dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.imem_rdata = imem[bus.imem_addr[7:0]];
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask
  task automatic step(input bit r, input bit h, input bit rv, input logic [15:0] rpc);
    exp_t e;
    bit go, issuing;
    @(posedge clk);
    #1;
    rst = r;
    bus.hazard = h;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    if (r) begin
      m_pc = 16'h0000; m_ir = 16'hF000; m_pc1 = 16'h0000;
      m_fetched = 0; m_halt = 0; m_ovf = 0; m_stalls = 0;
      return;
    end
    go = !m_halt && (!h || m_stalls == 3);
    issuing = go && m_fetched;
    e.addr = m_pc; e.ir = m_ir; e.pc1 = m_pc1; e.iss = go ? m_ir : 16'hF000;
    e.iv = issuing; e.ovf = m_ovf; e.hlt = m_halt; e.cnt = 2'(m_stalls);
    sq.push_back(e);
    if (issuing) iq.push_back(m_ir);
    if (go && h) m_ovf = 1;
    if (rv) begin
      m_pc = rpc; m_ir = 16'hF000; m_fetched = 0; m_stalls = 0; m_halt = 0;
    end else if (m_halt) begin
    end else if (issuing && m_ir[15:12] == 4'hE) begin
      m_halt = 1; m_ir = 16'hF000; m_fetched = 0; m_stalls = 0;
    end else if (go) begin
      m_ir = imem[m_pc[7:0]]; m_fetched = 1; m_pc1 = m_pc + 16'd1; m_pc = m_pc + 16'd1; m_stalls = 0;
    end else m_stalls++;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sq.size() != 0) begin
        e = sq.pop_front();
        chk("imem_addr", bus.imem_addr, e.addr);
        chk("if_id_instr", bus.if_id_instr, e.ir);
        chk("if_id_pc1", bus.if_id_pc1, e.pc1);
        chk("issue_instr", bus.issue_instr, e.iss);
        chk("issue_valid", 16'(bus.issue_valid), 16'(e.iv));
        chk("stall_cnt", 16'(bus.stall_cnt), 16'(e.cnt));
        chk("stall_overflow", 16'(bus.stall_overflow), 16'(e.ovf));
        chk("halted", 16'(bus.halted), 16'(e.hlt));
        if (bus.issue_valid === 1'b1) begin
          if (iq.size() != 0) chk("issue_order", bus.issue_instr, iq.pop_front());
          else begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_order: got %h required none pending", bus.issue_instr);
          end
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h0;
      imem[i] = w;
    end
    imem[0] = 16'h0123; imem[1] = 16'h1456; imem[2] = 16'h2789;
    imem[3] = 16'h1234; imem[4] = 16'h3333; imem[5] = 16'hE000;
    imem[255] = 16'h4321;
    bus.hazard = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (10) step(0, 1'($urandom), 0, 0);
    step(0, 0, 1, 16'h0000);
    repeat (4) step(0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    step(0, 1, 1, 16'h0040);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 16'hFFFF);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, h, rv;
      r = $urandom_range(0, 99) == 0;
      h = $urandom_range(0, 9) < 4;
      rv = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      step(r, h, rv, 16'($urandom));
    end
    step(0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("issue_drain", 16'(iq.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stall_unit.md
Name: fetch_stall_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 16-bit CPU, sitting directly upstream of the hazard detector. It owns the PC and the IF/ID instruction register. It presents the IF/ID instruction to the hazard detector, and it consumes the detector's hazard flag to freeze the PC and IF/ID and inject bubbles into ID/EX. It also applies branch/jump redirects, which flush the IF/ID register, and it handles HLT.

Parameters:
NOP_INSTR, 16'hF000, bubble encoding written into IF/ID and issued to ID/EX (non-writing; opcode 4'hF with zero fields)
HALT_OP, 4'hE, opcode of HLT
MAX_STALL, 3, maximum consecutive stall cycles before forced release (matches the 3-deep hazard history)
PC_RESET, 16'h0000, PC value after reset

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
imem_addr  output  16  instruction-memory address (= PC)
imem_rdata  input  16  instruction word; combinational read of imem_addr, valid in the same cycle
hazard  input  1  from hazard detector, referring to the current if_id_instr
redirect_valid  input  1  taken branch / JAL / JR resolved downstream
redirect_pc  input  16  redirect target
if_id_instr  output  16  IF/ID instruction register; drives the detector's instr_in
if_id_pc1  output  16  PC+1 of the instruction in IF/ID (JAL link value)
issue_instr  output  16  instruction issued to ID/EX: NOP_INSTR when stalling, flushing or halted, else if_id_instr
issue_valid  output  1  1 when issue_instr is a real instruction
stall_cnt  output  2  consecutive stall cycles so far
stall_overflow  output  1  sticky; set when a forced release occurs
halted  output  1  1 in state HALT

Behaviour:
- Reset (rst=1 at posedge)
  - pc=PC_RESET, if_id_instr=NOP_INSTR, if_id_pc1=0, state=RUN, stall_cnt=0, stall_overflow=0.
  - issue_valid=0 in the first cycle after reset, because IF/ID holds NOP.
  - Reset mid-stall or mid-halt aborts immediately to these values.
- States: RUN, STALL, HALT. Priority per cycle: rst > redirect_valid > HALT > hazard > normal advance.
- Redirect (any state)
  - Next cycle: pc=redirect_pc, if_id_instr=NOP_INSTR, state=RUN, stall_cnt=0.
  - issue_instr in the redirect cycle is still computed from the current hazard/state; the redirecting instruction is already downstream.
- RUN, hazard=0
  - issue_instr=if_id_instr, issue_valid=1.
  - Next cycle: if_id_instr=imem_rdata, if_id_pc1=pc+1, pc=pc+1 (mod 2^16; 16'hFFFF wraps to 0).
- RUN, hazard=1
  - issue_instr=NOP_INSTR, issue_valid=0.
  - pc and IF/ID held; stall_cnt=1; state goes to STALL.
- STALL, hazard=1 and stall_cnt<MAX_STALL
  - Bubble issued, hold, stall_cnt+1.
- STALL, hazard=0
  - Behaves exactly as RUN with hazard=0 (issue and advance); stall_cnt=0; state goes to RUN.
- STALL, hazard=1 and stall_cnt==MAX_STALL
  - Forced release: issue if_id_instr and advance as in RUN.
  - stall_overflow=1 (sticky until rst); stall_cnt=0; state goes to RUN.
- HLT handling
  - When if_id_instr[15:12]==HALT_OP and it issues (hazard=0), the next state is HALT.
  - In HALT: pc frozen, if_id_instr=NOP_INSTR, issue_valid=0, halted=1.
  - Leave HALT only on rst or redirect_valid.
- Combinational outputs
  - imem_addr is combinational from pc.
  - issue_instr and issue_valid are combinational from state, hazard and if_id_instr.
  - All other outputs are registered.
- No combinational path from hazard to imem_addr.

Decomposition:
- Shared definitions: opcode constants (LW, SW, LHB, LLB, JAL, JR, EXEC, HLT), NOP encoding, and the state encoding (RUN=2'd0, STALL=2'd1, HALT=2'd2).
- One natural sub-module: pc_reg, the PC register with hold/load/increment and its next-PC mux; the rest stays inline.

Test Plan:
- Reset, then imem[0..2]=ADD,SUB,AND with hazard=0 → imem_addr 0,1,2,3 on consecutive cycles; issue_valid=0 in the first cycle after reset, then ADD,SUB,AND issued in order with issue_valid=1.
- Hazard held 2 cycles with IF/ID=16'h1234 → two cycles of issue_instr=NOP_INSTR, issue_valid=0, pc frozen, stall_cnt 1 then 2; on the third cycle 16'h1234 issues and pc advances by 1.
- Hazard stuck at 1 → stalls for 3 cycles; on the 4th, forced issue, stall_overflow=1 and it stays 1.
- redirect_valid=1, redirect_pc=16'h0040 while stalled with stall_cnt=2 → next cycle pc=16'h0040, if_id_instr=NOP_INSTR, state RUN, stall_cnt=0.
- HLT at address 5 → after it issues, halted=1, pc stays 6, issue_valid=0 for 10 cycles; a redirect to 0 resumes fetch.
- pc=16'hFFFF, no hazard → next pc=16'h0000, with if_id_pc1=16'h0000.
